add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter.sv | 94 +++++++++
 tb/tb_add_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one registered adder among NUM_REQ requesters.
// Three-phase transaction: grant/capture, add, hold result until consumed.
module add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH:0]           rsp_sum,
  output logic [IDW-1:0]           rsp_id,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [IDW-1:0]       r_rr_ptr;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [IDW-1:0]       r_id;
  logic [WIDTH:0]       r_sum;

  logic [NUM_REQ-1:0]   w_grant;
  logic [IDW-1:0]       w_win;
  logic                 w_found;
  logic [IDW-1:0]       w_next_ptr;

  // Scan starts at the pointer and wraps; the first valid requester wins.
  always_comb begin
    logic [IDW-1:0] v_idx;
    w_grant = '0;
    w_win   = '0;
    w_found = 1'b0;
    v_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      v_idx = IDW'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[v_idx]) begin
        w_found        = 1'b1;
        w_win          = v_idx;
        w_grant[v_idx] = 1'b1;
      end
    end
  end

  assign w_next_ptr = (w_win == IDW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_found)   w_next = CALC;
      CALC:                   w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_id     <= '0;
      r_sum    <= '0;
    end else begin
      if (r_state == IDLE && w_found) begin
        r_a      <= req_a[w_win*WIDTH +: WIDTH];
        r_b      <= req_b[w_win*WIDTH +: WIDTH];
        r_id     <= w_win;
        r_rr_ptr <= w_next_ptr;
      end
      if (r_state == CALC) r_sum <= {1'b0, r_a} + {1'b0, r_b};
    end
  end

  assign req_ready = (r_state == IDLE && rst_n) ? w_grant : '0;
  assign rsp_valid = (r_state == RESP);
  assign rsp_sum   = r_sum;
  assign rsp_id    = r_id;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: directed table, hand sequences and
// randomized traffic against a transaction-level reference model.
module tb_add_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid, rsp_ready, busy;
  logic [W:0]     rsp_sum;
  logic [1:0]     rsp_id;

  add_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one transaction in flight, aged in edges since acceptance.
  int m_ptr = 0, m_age = 0, m_sum = 0, m_id = 0, m_win = -1;
  bit m_busy = 0;

  // Values sampled at the most recent check point.
  logic [N-1:0] s_ready;
  logic         s_valid, s_busy;
  int           s_sum, s_id;

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(int ptr, logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // Check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    int exp_gnt;
    @(negedge clk);
    s_ready = req_ready; s_valid = rsp_valid; s_busy = busy;
    s_sum = int'(rsp_sum); s_id = int'(rsp_id);
    m_win = (!m_busy && rst_n) ? rr_pick(m_ptr, req_valid) : -1;
    exp_gnt = (m_win >= 0) ? (1 << m_win) : 0;
    chk("req_ready", int'(s_ready), exp_gnt);
    chk("rsp_valid", int'(s_valid), int'(m_busy && m_age >= 2));
    chk("busy", int'(s_busy), int'(m_busy));
    if (m_busy && m_age >= 2) begin
      chk("rsp_sum", s_sum, m_sum);
      chk("rsp_id", s_id, m_id);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_ptr = 0; m_sum = 0; m_id = 0; m_age = 0;
    end else if (m_win >= 0) begin
      m_busy = 1; m_age = 1; m_id = m_win;
      m_sum  = int'((req_a >> (m_win*W)) & 4'hF) + int'((req_b >> (m_win*W)) & 4'hF);
      m_ptr  = (m_win + 1) % N;
    end else if (m_busy) begin
      if (m_age >= 2 && rsp_ready) m_busy = 0;
      else if (m_age < 2) m_age++;
    end
    #1;
  endtask

  typedef struct {
    logic [N-1:0]   valid;
    logic [N*W-1:0] a, b;
    logic [N-1:0]   gnt;
    int             sum;
    int             id;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int gids[$];
    int gcyc[$];
    int first_sum, first_id;

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #1;
    step(); step();
    chk("reset_rsp_sum", s_sum, 0);
    chk("reset_rsp_id", s_id, 0);
    chk("reset_busy", int'(s_busy), 0);
    rst_n = 1'b1;

    // Directed transactions; the pointer carries over from each row to the next.
    tbl[0] = '{4'b0100, 16'h0300, 16'h0500, 4'b0100, 8,    2};
    tbl[1] = '{4'b1001, 16'hF001, 16'hF001, 4'b1000, 'h1E, 3};
    tbl[2] = '{4'b1001, 16'hF001, 16'hF001, 4'b0001, 2,    0};
    tbl[3] = '{4'b1111, 16'h4321, 16'h1111, 4'b0010, 3,    1};
    tbl[4] = '{4'b0001, 16'h000A, 16'h0007, 4'b0001, 17,   0};
    tbl[5] = '{4'b1100, 16'h9800, 16'h7600, 4'b0100, 14,   2};
    for (int i = 0; i < 6; i++) begin
      req_valid = tbl[i].valid; req_a = tbl[i].a; req_b = tbl[i].b; rsp_ready = 1'b1;
      step();
      chk($sformatf("tbl%0d_grant", i), int'(s_ready), int'(tbl[i].gnt));
      req_valid = '0; req_a = '0; req_b = '0;
      step();
      chk($sformatf("tbl%0d_calc_valid", i), int'(s_valid), 0);
      step();
      chk($sformatf("tbl%0d_valid", i), int'(s_valid), 1);
      chk($sformatf("tbl%0d_sum", i), s_sum, tbl[i].sum);
      chk($sformatf("tbl%0d_id", i), s_id, tbl[i].id);
    end

    // Round-robin fairness with all requesters continuously valid.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req_valid = 4'b1111; req_a = 16'h1234; req_b = 16'h1111; rsp_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      for (int j = 0; j < N; j++)
        if (s_ready[j]) begin gids.push_back(j); gcyc.push_back(c); end
    end
    chk("rr_grant_count", gids.size(), 5);
    for (int j = 0; j < gids.size() && j < 5; j++) begin
      chk($sformatf("rr_grant%0d", j), gids[j], j % N);
      chk($sformatf("rr_cycle%0d", j), gcyc[j], 3 * j);
    end

    // Reset during CALC abandons the transaction.
    req_valid = '0; rsp_ready = 1'b1;
    step(); step();
    req_valid = 4'b1111; req_a = 16'h000C; req_b = 16'h0009;
    step();
    req_valid = '0;
    rst_n = 1'b0;
    step();
    chk("midrst_ready", int'(s_ready), 0);
    rst_n = 1'b1;
    step();
    chk("midrst_busy", int'(s_busy), 0);
    chk("midrst_valid", int'(s_valid), 0);
    req_valid = 4'b1111; rsp_ready = 1'b0;
    step();
    chk("midrst_grant", int'(s_ready), 1);

    // Backpressure: hold the result for five cycles.
    step();
    step();
    first_sum = s_sum; first_id = s_id;
    chk("bp_sum", first_sum, 21);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("bp_valid", int'(s_valid), 1);
      chk("bp_sum_stable", s_sum, first_sum);
      chk("bp_id_stable", s_id, first_id);
      chk("bp_ready_low", int'(s_ready), 0);
    end
    rsp_ready = 1'b1;
    step();
    req_valid = '0;
    step();
    chk("bp_idle_busy", int'(s_busy), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      req_valid = N'($urandom);
      req_a     = (N*W)'($urandom);
      req_b     = (N*W)'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 59) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
